// File: rtl/controller_pkg.sv
// Shared opcode encodings and the packed control word for the instruction-decode
// control unit. Used by controller_decode and controller.
package controller_pkg;

  typedef logic [5:0] opcode_t;

  localparam opcode_t OP_RTYPE = 6'b000000;
  localparam opcode_t OP_J     = 6'b000010;
  localparam opcode_t OP_BEQ   = 6'b000100;
  localparam opcode_t OP_BNE   = 6'b000101;
  localparam opcode_t OP_ADDI  = 6'b001000;
  localparam opcode_t OP_SLTI  = 6'b001010;
  localparam opcode_t OP_ANDI  = 6'b001100;
  localparam opcode_t OP_ORI   = 6'b001101;
  localparam opcode_t OP_LW    = 6'b100011;
  localparam opcode_t OP_SW    = 6'b101011;

  // One bit per registered control strobe, MSB first in port order.
  typedef struct packed {
    logic reg_dst;
    logic alu_op;
    logic alu_zero;
    logic alu_src;
    logic branch;
    logic mem_read;
    logic mem_to_reg;
    logic reg_write;
    logic pc_src;
    logic mem_write;
  } ctrl_word_t;

  localparam ctrl_word_t CTRL_NONE = '0;

  // Datapath-level consistency rules every decoded word must satisfy.
  function automatic logic ctrl_legal(input ctrl_word_t c);
    logic ok;
    ok = 1'b1;
    if (c.mem_read && c.mem_write) ok = 1'b0;
    if (c.mem_to_reg && !c.mem_read) ok = 1'b0;
    if (c.pc_src && c.reg_write) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/controller_decode.sv
// Purely combinational opcode-to-control-word decoder.
// Jump (j) decode is only present when CONTROLLER_JUMP_EN is defined.
module controller_decode
  import controller_pkg::*;
(
  input  logic [31:0] instruction,
  output ctrl_word_t  ctrl
);

  opcode_t opcode;
  logic    is_nop;

  assign opcode = instruction[31:26];
  assign is_nop = (instruction == 32'h0000_0000);

  always_comb begin
    ctrl = CTRL_NONE;
    case (opcode)
      OP_RTYPE: begin
        // The all-zero word shares the R-type opcode but must stay inert.
        if (!is_nop) begin
          ctrl.reg_dst   = 1'b1;
          ctrl.alu_op    = 1'b1;
          ctrl.reg_write = 1'b1;
        end
      end
      OP_LW: begin
        ctrl.alu_src    = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
      end
      OP_SW: begin
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      OP_BEQ: begin
        ctrl.branch   = 1'b1;
        ctrl.alu_zero = 1'b1;
        ctrl.pc_src   = 1'b1;
      end
      OP_BNE: begin
        ctrl.branch = 1'b1;
        ctrl.pc_src = 1'b1;
      end
      OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: begin
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
`ifdef CONTROLLER_JUMP_EN
      OP_J: begin
        ctrl.pc_src = 1'b1;
      end
`endif
      default: ctrl = CTRL_NONE;
    endcase
  end

endmodule

// File: rtl/controller.sv
// Instruction-decode control unit: registers the decoded control word one clock
// after the instruction is presented. Optional j support via CONTROLLER_JUMP_EN.
module controller
  import controller_pkg::*;
(
  input  logic        Clk,
  input  logic        Rst,
  input  logic [31:0] Instruction,
  output logic        RegDst,
  output logic        ALUOp,
  output logic        ALUZero,
  output logic        ALUSrc,
  output logic        Branch,
  output logic        MemRead,
  output logic        MemtoReg,
  output logic        RegWrite,
  output logic        PCSrc,
  output logic        MemWrite
);

  ctrl_word_t dec_ctrl;
  ctrl_word_t ctrl_d;
  ctrl_word_t ctrl_q;

  controller_decode u_decode (
    .instruction (Instruction),
    .ctrl        (dec_ctrl)
  );

  always_comb begin
    ctrl_d = dec_ctrl;
  end

  // Reset wins over decode, so a pending instruction is simply dropped.
  always_ff @(posedge Clk) begin
    if (Rst) ctrl_q <= CTRL_NONE;
    else     ctrl_q <= ctrl_d;
  end

  assign RegDst   = ctrl_q.reg_dst;
  assign ALUOp    = ctrl_q.alu_op;
  assign ALUZero  = ctrl_q.alu_zero;
  assign ALUSrc   = ctrl_q.alu_src;
  assign Branch   = ctrl_q.branch;
  assign MemRead  = ctrl_q.mem_read;
  assign MemtoReg = ctrl_q.mem_to_reg;
  assign RegWrite = ctrl_q.reg_write;
  assign PCSrc    = ctrl_q.pc_src;
  assign MemWrite = ctrl_q.mem_write;

`ifndef SYNTHESIS
  a_ctrl_legal: assert property (@(posedge Clk) ctrl_legal(ctrl_q));
`endif

endmodule

// File: tb/tb_controller.sv
// Directed, table-driven bench for controller: expected control words are written
// by hand in output order {RegDst,ALUOp,ALUZero,ALUSrc,Branch,MemRead,MemtoReg,RegWrite,PCSrc,MemWrite}.
module tb_controller;

  logic        Clk;
  logic        Rst;
  logic [31:0] Instruction;
  logic        RegDst, ALUOp, ALUZero, ALUSrc, Branch;
  logic        MemRead, MemtoReg, RegWrite, PCSrc, MemWrite;

  controller dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .Instruction (Instruction),
    .RegDst      (RegDst),
    .ALUOp       (ALUOp),
    .ALUZero     (ALUZero),
    .ALUSrc      (ALUSrc),
    .Branch      (Branch),
    .MemRead     (MemRead),
    .MemtoReg    (MemtoReg),
    .RegWrite    (RegWrite),
    .PCSrc       (PCSrc),
    .MemWrite    (MemWrite)
  );

  // ---------------- clock / reset ----------------
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // ---------------- expected words ----------------
  localparam logic [9:0] E_NONE = 10'b00_0000_0000;
  localparam logic [9:0] E_R    = 10'b11_0000_0100;
  localparam logic [9:0] E_LW   = 10'b00_0101_1100;
  localparam logic [9:0] E_SW   = 10'b00_0100_0001;
  localparam logic [9:0] E_BEQ  = 10'b00_1010_0010;
  localparam logic [9:0] E_BNE  = 10'b00_0010_0010;
  localparam logic [9:0] E_IMM  = 10'b00_0100_0100;
`ifdef CONTROLLER_JUMP_EN
  localparam logic [9:0] E_J    = 10'b00_0000_0010;
`else
  localparam logic [9:0] E_J    = 10'b00_0000_0000;
`endif

  typedef struct {
    logic [31:0] instr;
    logic [9:0]  exp;
    string       name;
  } vec_t;

  vec_t       vecs[15];
  logic [9:0] exp_q[$];
  int         tests_run;
  int         tests_failed;

  function automatic logic [9:0] actual_word();
    return {RegDst, ALUOp, ALUZero, ALUSrc, Branch,
            MemRead, MemtoReg, RegWrite, PCSrc, MemWrite};
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string name);
    logic [9:0] exp;
    logic [9:0] act;
    tests_run++;
    act = actual_word();
    if (exp_q.size() == 0) begin
      tests_failed++;
      $display("FAIL %s: no expected value queued (got %b)", name, act);
    end else begin
      exp = exp_q.pop_front();
      if (act !== exp) begin
        tests_failed++;
        $display("FAIL %s: got %b expected %b", name, act, exp);
      end
    end
  endtask

  // ---------------- drivers ----------------
  // Change inputs on the falling edge, sample #1 after the rising edge.
  task automatic drive(input logic rst, input logic [31:0] instr, input logic [9:0] exp);
    @(negedge Clk);
    Rst         = rst;
    Instruction = instr;
    exp_q.push_back(exp);
    @(posedge Clk);
    #1;
  endtask

  task automatic drive_check(input logic rst, input logic [31:0] instr,
                             input logic [9:0] exp, input string name);
    drive(rst, instr, exp);
    check(name);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    Rst          = 1'b1;
    Instruction  = 32'h0000_0000;

    vecs[0]  = '{32'h0022_1820, E_R,    "add"};
    vecs[1]  = '{32'h8C22_0004, E_LW,   "lw"};
    vecs[2]  = '{32'hAC22_0004, E_SW,   "sw"};
    vecs[3]  = '{32'h1022_0002, E_BEQ,  "beq"};
    vecs[4]  = '{32'h1422_0002, E_BNE,  "bne"};
    vecs[5]  = '{32'h2022_0005, E_IMM,  "addi"};
    vecs[6]  = '{32'h3022_00FF, E_IMM,  "andi"};
    vecs[7]  = '{32'h3422_00F0, E_IMM,  "ori"};
    vecs[8]  = '{32'h2822_0003, E_IMM,  "slti"};
    vecs[9]  = '{32'h0800_0010, E_J,    "j"};
    vecs[10] = '{32'h0000_0000, E_NONE, "nop"};
    vecs[11] = '{32'h0000_0001, E_R,    "rtype_min_nonzero"};
    vecs[12] = '{32'hFC00_0000, E_NONE, "op_111111"};
    vecs[13] = '{32'h3C01_1234, E_NONE, "lui_unsupported"};
    vecs[14] = '{32'h8C22_0004, E_LW,   "lw_after_lui"};

    // Reset with a live instruction present: reset must win.
    drive_check(1'b1, 32'h8C22_0004, E_NONE, "reset_priority");
    drive_check(1'b1, 32'h0000_0000, E_NONE, "reset_state");

    for (int i = 0; i < 15; i++) begin
      drive_check(1'b0, vecs[i].instr, vecs[i].exp, vecs[i].name);
    end

    // Mid-cycle instruction change must not reach the outputs before the next edge.
    drive_check(1'b0, 32'h0022_1820, E_R, "hold_load");
    Instruction = 32'hAC22_0004;
    exp_q.push_back(E_R);
    #3;
    check("hold_between_edges");
    @(posedge Clk);
    #1;
    exp_q.push_back(E_SW);
    check("hold_next_edge");

    // Reset mid-stream while lw is held, then recovery with no warm-up.
    drive_check(1'b0, 32'h8C22_0004, E_LW,   "midrst_lw");
    drive_check(1'b1, 32'h8C22_0004, E_NONE, "midrst_assert");
    drive_check(1'b0, 32'h8C22_0004, E_LW,   "midrst_release");

    // Back-to-back different branches, then a NOP bubble.
    drive_check(1'b0, 32'h1022_0002, E_BEQ,  "b2b_beq");
    drive_check(1'b0, 32'h1422_0002, E_BNE,  "b2b_bne");
    drive_check(1'b0, 32'h0000_0000, E_NONE, "b2b_nop");

    if (exp_q.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL scoreboard_drain: got %0d leftover expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
